adf_spi_sequencer: RTL and testbench

ADF_SPI_SEQUENCER -- requirements
Module: adf_spi_sequencer

---
 rtl/adf_spi_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_adf_spi_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adf_spi_sequencer.sv
// Sequences register accesses on an SPI core to shift one 24-bit ADF word out MSB byte first.
// Every core access is two cycles wide followed by an idle cycle; status waits are bounded.
module adf_spi_sequencer #(
  parameter logic [15:0] SS_MASK      = 16'h0001,
  parameter int unsigned POLL_TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  input  logic [23:0] cmd_data,
  output logic        cmd_ready,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        spi_select,
  output logic [2:0]  spi_addr,
  output logic        spi_write_n,
  output logic        spi_read_n,
  output logic [15:0] spi_wdata,
  input  logic [15:0] spi_rdata
);

  typedef enum logic [3:0] {
    IDLE, SEL, SSO_ON, POLL_TRDY, WR_BYTE, POLL_TMT, SSO_OFF, CLR_STAT, DONE
  } state_t;

  localparam logic [1:0]  PH_A        = 2'd0;
  localparam logic [1:0]  PH_B        = 2'd1;
  localparam logic [1:0]  PH_GAP      = 2'd2;
  localparam logic [2:0]  ADDR_TXDATA = 3'd1;
  localparam logic [2:0]  ADDR_STATUS = 3'd2;
  localparam logic [2:0]  ADDR_CTRL   = 3'd3;
  localparam logic [2:0]  ADDR_SS     = 3'd5;
  localparam logic [10:0] POLL_LIMIT  = 11'(POLL_TIMEOUT);

  state_t      state_r, state_s;
  logic [1:0]  phase_r, phase_s;
  logic [23:0] word_r, word_s;
  logic [1:0]  byte_cnt_r, byte_cnt_s;
  logic [10:0] poll_cnt_r, poll_cnt_s;
  logic        hit_r, hit_s;
  logic        error_r, error_s;
  logic        sel_r, sel_s;
  logic [2:0]  addr_r, addr_s;
  logic        wn_r, wn_s;
  logic        rn_r, rn_s;
  logic [15:0] wdata_r, wdata_s;
  logic        cmd_ready_r, busy_r, done_r;
  logic        unused_rdata_s;

  // Only TRDY and TMT are consulted from the status register.
  assign unused_rdata_s = ^{spi_rdata[15:7], spi_rdata[4:0]};

  function automatic logic [7:0] byte_of(input logic [23:0] w, input logic [1:0] idx);
    case (idx)
      2'd0:    byte_of = w[23:16];
      2'd1:    byte_of = w[15:8];
      2'd2:    byte_of = w[7:0];
      default: byte_of = 8'h00;
    endcase
  endfunction

  // Next-state logic: bus states step A -> B -> GAP, and transitions are taken in the gap cycle.
  always_comb begin
    state_s    = state_r;
    phase_s    = phase_r;
    word_s     = word_r;
    byte_cnt_s = byte_cnt_r;
    poll_cnt_s = poll_cnt_r;
    hit_s      = hit_r;
    error_s    = error_r;
    case (state_r)
      IDLE: begin
        phase_s = PH_A;
        if (cmd_valid && cmd_ready_r) begin
          word_s     = cmd_data;
          error_s    = 1'b0;
          byte_cnt_s = 2'd0;
          poll_cnt_s = 11'd0;
          state_s    = SEL;
        end else begin
          state_s = IDLE;
        end
      end
      DONE: state_s = IDLE;
      default: begin
        case (phase_r)
          PH_A: phase_s = PH_B;
          PH_B: begin
            phase_s = PH_GAP;
            if ((state_r == POLL_TRDY) || (state_r == POLL_TMT)) begin
              hit_s      = (state_r == POLL_TRDY) ? spi_rdata[6] : spi_rdata[5];
              poll_cnt_s = poll_cnt_r + 11'd1;
            end else begin
              hit_s = 1'b0;
            end
          end
          PH_GAP: begin
            phase_s = PH_A;
            case (state_r)
              SEL: state_s = SSO_ON;
              SSO_ON: begin
                state_s    = POLL_TRDY;
                poll_cnt_s = 11'd0;
              end
              POLL_TRDY, POLL_TMT: begin
                if (hit_r) begin
                  state_s = (state_r == POLL_TRDY) ? WR_BYTE : SSO_OFF;
                end else if (poll_cnt_r >= POLL_LIMIT) begin
                  error_s = 1'b1;
                  state_s = SSO_OFF;
                end else begin
                  state_s = state_r;
                end
              end
              WR_BYTE: begin
                poll_cnt_s = 11'd0;
                if (byte_cnt_r == 2'd2) begin
                  state_s = POLL_TMT;
                end else begin
                  byte_cnt_s = byte_cnt_r + 2'd1;
                  state_s    = POLL_TRDY;
                end
              end
              SSO_OFF:  state_s = CLR_STAT;
              CLR_STAT: state_s = DONE;
              default:  state_s = IDLE;
            endcase
          end
          default: phase_s = PH_A;
        endcase
      end
    endcase
  end

  // Bus values for the upcoming cycle, registered below so the core sees glitch-free strobes.
  always_comb begin
    sel_s   = 1'b0;
    addr_s  = 3'd0;
    wn_s    = 1'b1;
    rn_s    = 1'b1;
    wdata_s = 16'h0000;
    if (phase_s != PH_GAP) begin
      case (state_s)
        SEL:      begin sel_s = 1'b1; addr_s = ADDR_SS;     wn_s = 1'b0; wdata_s = SS_MASK;  end
        SSO_ON:   begin sel_s = 1'b1; addr_s = ADDR_CTRL;   wn_s = 1'b0; wdata_s = 16'h0400; end
        POLL_TRDY,
        POLL_TMT: begin sel_s = 1'b1; addr_s = ADDR_STATUS; rn_s = 1'b0; end
        WR_BYTE:  begin
          sel_s   = 1'b1;
          addr_s  = ADDR_TXDATA;
          wn_s    = 1'b0;
          wdata_s = {8'h00, byte_of(word_s, byte_cnt_s)};
        end
        SSO_OFF:  begin sel_s = 1'b1; addr_s = ADDR_CTRL;   wn_s = 1'b0; end
        CLR_STAT: begin sel_s = 1'b1; addr_s = ADDR_STATUS; wn_s = 1'b0; end
        default:  sel_s = 1'b0;
      endcase
    end else begin
      sel_s = 1'b0;
    end
  end

  // State and output registers; reset abandons any word without touching SSO.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      phase_r     <= PH_A;
      word_r      <= 24'h000000;
      byte_cnt_r  <= 2'd0;
      poll_cnt_r  <= 11'd0;
      hit_r       <= 1'b0;
      error_r     <= 1'b0;
      sel_r       <= 1'b0;
      addr_r      <= 3'd0;
      wn_r        <= 1'b1;
      rn_r        <= 1'b1;
      wdata_r     <= 16'h0000;
      cmd_ready_r <= 1'b1;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      phase_r     <= phase_s;
      word_r      <= word_s;
      byte_cnt_r  <= byte_cnt_s;
      poll_cnt_r  <= poll_cnt_s;
      hit_r       <= hit_s;
      error_r     <= error_s;
      sel_r       <= sel_s;
      addr_r      <= addr_s;
      wn_r        <= wn_s;
      rn_r        <= rn_s;
      wdata_r     <= wdata_s;
      cmd_ready_r <= (state_s == IDLE);
      busy_r      <= (state_s != IDLE);
      done_r      <= (state_s == DONE);
    end
  end

  assign cmd_ready   = cmd_ready_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign error       = error_r;
  assign spi_select  = sel_r;
  assign spi_addr    = addr_r;
  assign spi_write_n = wn_r;
  assign spi_read_n  = rn_r;
  assign spi_wdata   = wdata_r;

endmodule

// File: tb/tb_adf_spi_sequencer.sv
// Scoreboard bench: two sequencer instances (default and POLL_TIMEOUT=4) share one SPI core model;
// expected bus accesses and done/error outcomes are queued by stimulus and checked by a monitor.
module tb_adf_spi_sequencer;
  logic        clk, reset, cmd_valid, use_b;
  logic [23:0] cmd_data;
  logic [15:0] spi_rdata;
  logic        a_ready, a_busy, a_done, a_error, a_sel, a_wn, a_rn;
  logic        b_ready, b_busy, b_done, b_error, b_sel, b_wn, b_rn;
  logic [2:0]  a_addr, b_addr;
  logic [15:0] a_wdata, b_wdata;
  logic        a_valid, b_valid;
  logic        m_ready, m_busy, m_done, m_error, m_sel, m_wn, m_rn;
  logic [2:0]  m_addr;
  logic [15:0] m_wdata;

  assign a_valid = cmd_valid & ~use_b;
  assign b_valid = cmd_valid & use_b;
  assign m_ready = use_b ? b_ready : a_ready;
  assign m_busy  = use_b ? b_busy  : a_busy;
  assign m_done  = use_b ? b_done  : a_done;
  assign m_error = use_b ? b_error : a_error;
  assign m_sel   = use_b ? b_sel   : a_sel;
  assign m_wn    = use_b ? b_wn    : a_wn;
  assign m_rn    = use_b ? b_rn    : a_rn;
  assign m_addr  = use_b ? b_addr  : a_addr;
  assign m_wdata = use_b ? b_wdata : a_wdata;

  adf_spi_sequencer dut_a (
    .clk(clk), .reset(reset), .cmd_valid(a_valid), .cmd_data(cmd_data),
    .cmd_ready(a_ready), .busy(a_busy), .done(a_done), .error(a_error),
    .spi_select(a_sel), .spi_addr(a_addr), .spi_write_n(a_wn), .spi_read_n(a_rn),
    .spi_wdata(a_wdata), .spi_rdata(spi_rdata));

  adf_spi_sequencer #(.POLL_TIMEOUT(4)) dut_b (
    .clk(clk), .reset(reset), .cmd_valid(b_valid), .cmd_data(cmd_data),
    .cmd_ready(b_ready), .busy(b_busy), .done(b_done), .error(b_error),
    .spi_select(b_sel), .spi_addr(b_addr), .spi_write_n(b_wn), .spi_read_n(b_rn),
    .spi_wdata(b_wdata), .spi_rdata(spi_rdata));

  typedef struct packed { logic rd; logic [2:0] addr; logic [15:0] wdata; } acc_t;
  acc_t exp_q[$];
  logic exp_done_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cfg_hold_byte = -1;
  int   cfg_hold_n = 0;
  bit   cfg_stuck = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout/empty, expected event", name);
  endtask

  task automatic push_w(input logic [2:0] a, input logic [15:0] d);
    acc_t e;
    e.rd = 1'b0; e.addr = a; e.wdata = d;
    exp_q.push_back(e);
  endtask

  task automatic push_r();
    acc_t e;
    e.rd = 1'b1; e.addr = 3'd2; e.wdata = 16'h0000;
    exp_q.push_back(e);
  endtask

  // Expected access list for one word: hold_n TRDY=0 polls before byte hold_byte, pt = timeout.
  task automatic expect_word(input logic [23:0] d, input int hold_byte, input int hold_n,
                             input bit stuck, input int pt);
    bit to = 1'b0;
    int n;
    logic [7:0] b;
    push_w(3'd5, 16'h0001);
    push_w(3'd3, 16'h0400);
    for (int i = 0; i < 3 && !to; i++) begin
      n = (i == hold_byte) ? hold_n + 1 : 1;
      if (n > pt) begin
        repeat (pt) push_r();
        to = 1'b1;
      end else begin
        repeat (n) push_r();
        b = (i == 0) ? d[23:16] : (i == 1) ? d[15:8] : d[7:0];
        push_w(3'd1, {8'h00, b});
      end
    end
    if (!to) begin
      if (stuck) begin
        repeat (pt) push_r();
        to = 1'b1;
      end else begin
        push_r();
      end
    end
    push_w(3'd3, 16'h0000);
    push_w(3'd2, 16'h0000);
    exp_done_q.push_back(to);
  endtask

  // SPI core model: status is valid only in the 2nd cycle of a read, 16'hFFFF otherwise.
  initial begin : spi_model
    bit prev_sel;
    int wbytes, hold;
    logic [15:0] st;
    prev_sel = 1'b0; wbytes = 0; hold = 0;
    spi_rdata = 16'hFFFF;
    forever begin
      @(posedge clk);
      if (reset) begin
        prev_sel = 1'b0;
        spi_rdata <= 16'hFFFF;
      end else begin
        if (m_sel && !prev_sel) begin
          if (!m_wn && m_addr == 3'd5) begin wbytes = 0; hold = 0; end
          if (!m_wn && m_addr == 3'd1) begin
            wbytes++;
            if (wbytes == cfg_hold_byte) hold = cfg_hold_n;
          end
          if (!m_rn) begin
            st = 16'h0000;
            st[6] = (hold == 0);
            if (hold > 0) hold--;
            st[5] = !cfg_stuck;
            spi_rdata <= st;
          end else begin
            spi_rdata <= 16'hFFFF;
          end
        end else begin
          spi_rdata <= 16'hFFFF;
        end
        prev_sel = m_sel;
      end
    end
  end

  // Monitor: reconstructs each access, checks its shape, and pops the scoreboard.
  initial begin : monitor
    acc_t cur, e;
    logic cur_wn, cur_rn, ed;
    bit in_acc, prev_done;
    int cyc;
    in_acc = 1'b0; prev_done = 1'b0; cyc = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        in_acc = 1'b0;
        prev_done = 1'b0;
      end else begin
        if (m_sel) begin
          if (!in_acc) begin
            cur.rd = !m_rn; cur.addr = m_addr; cur.wdata = m_wdata;
            cur_wn = m_wn; cur_rn = m_rn;
            in_acc = 1'b1; cyc = 1;
            check("one_strobe", {31'd0, m_wn ^ m_rn}, 32'd1);
          end else begin
            cyc++;
            check("acc_stable", {11'd0, m_addr, m_wdata, m_wn, m_rn},
                  {11'd0, cur.addr, cur.wdata, cur_wn, cur_rn});
          end
        end else if (in_acc) begin
          in_acc = 1'b0;
          check("acc_len", 32'(cyc), 32'd2);
          check("idle_bus", {29'd0, m_wn, m_rn, |m_wdata}, {29'd0, 3'b110});
          if (exp_q.size() == 0) begin
            fail("unexpected_access");
          end else begin
            e = exp_q.pop_front();
            check("access", {12'd0, cur}, {12'd0, e});
          end
        end
        if (m_done) begin
          if (exp_done_q.size() == 0) begin
            fail("unexpected_done");
          end else begin
            ed = exp_done_q.pop_front();
            check("done_err_ready", {30'd0, m_error, m_ready}, {30'd0, ed, 1'b0});
          end
        end
        if (prev_done) check("after_done_ready", {30'd0, m_ready, m_busy}, {30'd0, 2'b10});
        prev_done = m_done;
      end
    end
  end

  task automatic send(input logic [23:0] d);
    int k = 0;
    while (!m_ready && k < 100) begin @(negedge clk); k++; end
    if (!m_ready) fail("send_ready_wait");
    cmd_data  = d;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("accept_busy_err", {30'd0, m_busy, m_error}, {30'd0, 2'b10});
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while (!m_done && k < 3000) begin
      @(negedge clk);
      cmd_data = 24'($urandom);
      k++;
    end
    if (!m_done) fail(name);
  endtask

  initial begin : stimulus
    int k;
    use_b = 1'b0; reset = 1'b1; cmd_valid = 1'b0; cmd_data = 24'h000000;
    repeat (3) @(negedge clk);
    check("reset_a", {6'd0, a_ready, a_busy, a_done, a_error, a_sel, a_wn, a_rn, a_addr, a_wdata},
          {6'd0, 7'b1000011, 3'd0, 16'h0000});
    check("reset_b", {6'd0, b_ready, b_busy, b_done, b_error, b_sel, b_wn, b_rn, b_addr, b_wdata},
          {6'd0, 7'b1000011, 3'd0, 16'h0000});
    reset = 1'b0;
    @(negedge clk);

    // single word, ideal core
    expect_word(24'h5A3C81, -1, 0, 1'b0, 1023);
    send(24'h5A3C81);
    wait_done("done_single");

    // five TRDY=0 polls before the second byte
    cfg_hold_byte = 1; cfg_hold_n = 5;
    expect_word(24'h5A3C81, 1, 5, 1'b0, 1023);
    send(24'h5A3C81);
    wait_done("done_trdy_wait");
    cfg_hold_byte = -1; cfg_hold_n = 0;

    // reset right after the first byte write
    push_w(3'd5, 16'h0001); push_w(3'd3, 16'h0400); push_r(); push_w(3'd1, 16'h005A);
    send(24'h5A3C81);
    k = 0;
    while (!(m_sel && !m_wn && m_addr == 3'd1) && k < 200) begin @(negedge clk); k++; end
    if (k >= 200) fail("mid_word_write_wait");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("reset_mid", {23'd0, m_ready, m_busy, m_done, m_sel, m_wn, m_rn, |m_wdata, m_addr == 3'd0, m_error},
          {23'd0, 9'b100011010});
    reset = 1'b0;
    check("reset_mid_queue", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    expect_word(24'h000001, -1, 0, 1'b0, 1023);
    send(24'h000001);
    wait_done("done_after_reset");

    // back-to-back with cmd_valid held; data garbage while busy
    expect_word(24'h123456, -1, 0, 1'b0, 1023);
    expect_word(24'hABCDEF, -1, 0, 1'b0, 1023);
    k = 0;
    while (!m_ready && k < 100) begin @(negedge clk); k++; end
    cmd_data = 24'h123456; cmd_valid = 1'b1;
    @(negedge clk);
    check("b2b_first_busy", {31'd0, m_busy}, 32'd1);
    k = 0;
    while (!m_done && k < 3000) begin
      cmd_data = 24'($urandom);
      @(negedge clk);
      k++;
    end
    if (!m_done) fail("b2b_first_done");
    cmd_data = 24'hABCDEF;
    @(negedge clk);
    check("b2b_gap_ready", {31'd0, m_ready}, 32'd1);
    @(negedge clk);
    check("b2b_second_accept", {31'd0, m_busy}, 32'd1);
    cmd_valid = 1'b0;
    wait_done("b2b_second_done");

    // timeout instance: TMT stuck, then boundary success on the 4th TRDY poll
    @(negedge clk);
    use_b = 1'b1;
    cfg_stuck = 1'b1;
    expect_word(24'hC0FFEE, -1, 0, 1'b1, 4);
    send(24'hC0FFEE);
    wait_done("done_timeout");
    @(negedge clk);
    check("error_sticky", {30'd0, m_error, m_ready}, {30'd0, 2'b11});
    cfg_stuck = 1'b0; cfg_hold_byte = 1; cfg_hold_n = 3;
    expect_word(24'h0F0F0F, 1, 3, 1'b0, 4);
    send(24'h0F0F0F);
    wait_done("done_boundary");
    @(negedge clk);
    @(negedge clk);

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    check("exp_done_empty", 32'(exp_done_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
